// File: rtl/display_scan_controller_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan controller.
package display_pkg;

   localparam logic [3:0] DIGIT_BLANK = 4'hF;
   localparam int         MAX_DIGITS  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_t;

   // Maps a logical one-hot enable onto the physical anode polarity.
   function automatic logic [MAX_DIGITS-1:0] anode_drive(input logic [MAX_DIGITS-1:0] en,
                                                         input logic                  active_low);
      return active_low ? ~en : en;
   endfunction

endpackage

// File: rtl/display_scan_controller_lz_blank_mask.sv
// Leading-zero mask: bit i is set when nibbles NUM_DIGITS-1..i are all zero (i > 0).
module lz_blank_mask #(
   parameter int NUM_DIGITS = 8
) (
   input  logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   mask
);

   logic zero_run;

   always_comb begin
      mask     = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_run = zero_run & (value[4*i +: 4] == 4'd0);
         mask[i]  = zero_run;
      end
   end

endmodule

// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS digits through one shared decoder with a blanking gap per slot
// and a shadow/active value buffer that only swaps on frame boundaries.
module display_scan_controller
   import display_pkg::*;
#(
   parameter int NUM_DIGITS       = 8,
   parameter int SCAN_DIV         = 100000,
   parameter int BLANK_CYCLES     = 1000,
   parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    lz_blank,
   output logic [3:0]              digit,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    frame_done,
   output scan_state_t             dbg_state,
   output logic                    dbg_pending
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int VW = 4 * NUM_DIGITS;

   localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0]         SLOT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = ANODE_ACTIVE_LOW ? '1 : '0;

   scan_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [IW-1:0] idx, idx_n;

   logic [VW-1:0]         active_val, active_val_n, shadow_val, shadow_val_n;
   logic [NUM_DIGITS-1:0] active_dp, active_dp_n, shadow_dp, shadow_dp_n;
   logic                  pending, pending_n;
   logic                  frame_end;
   logic [NUM_DIGITS-1:0] blank_mask;

   logic [3:0]            digit_n;
   logic                  dp_n;
   logic                  frame_done_n;
   logic [NUM_DIGITS-1:0] onehot;
   logic [MAX_DIGITS-1:0] onehot_full;
   logic [MAX_DIGITS-1:0] anode_full;
   logic [NUM_DIGITS-1:0] anode_n;

   assign frame_end   = enable && (state == SHOW) && (cnt == SLOT_LAST) && (idx == IDX_LAST);
   assign dbg_state   = state;
   assign dbg_pending = pending;

   // State register; outputs are registered from the next-state view so they line up with it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         digit      <= DIGIT_BLANK;
         dp         <= 1'b0;
         anode      <= ANODE_OFF;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         digit      <= digit_n;
         dp         <= dp_n;
         anode      <= anode_n;
         frame_done <= frame_done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      if (!enable) begin
         state_n = IDLE;
         cnt_n   = '0;
         idx_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_n = BLANK;
               cnt_n   = '0;
               idx_n   = '0;
            end
            BLANK: begin
               cnt_n = cnt + CW'(1);
               if (cnt == BLANK_LAST) state_n = SHOW;
            end
            SHOW: begin
               if (cnt == SLOT_LAST) begin
                  state_n = BLANK;
                  cnt_n   = '0;
                  idx_n   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
               idx_n   = '0;
            end
         endcase
      end
   end

   // A strobe at a swap point bypasses the shadow; otherwise it waits for the frame boundary.
   always_comb begin
      active_val_n = active_val;
      active_dp_n  = active_dp;
      shadow_val_n = shadow_val;
      shadow_dp_n  = shadow_dp;
      pending_n    = pending;
      if ((state == IDLE) || frame_end) begin
         if (load) begin
            active_val_n = value;
            active_dp_n  = dp_mask;
            pending_n    = 1'b0;
         end else if (pending) begin
            active_val_n = shadow_val;
            active_dp_n  = shadow_dp;
            pending_n    = 1'b0;
         end
      end else if (load) begin
         shadow_val_n = value;
         shadow_dp_n  = dp_mask;
         pending_n    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_val <= '0;
         active_dp  <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         pending    <= 1'b0;
      end else begin
         active_val <= active_val_n;
         active_dp  <= active_dp_n;
         shadow_val <= shadow_val_n;
         shadow_dp  <= shadow_dp_n;
         pending    <= pending_n;
      end
   end

   // Mask follows the value the active register will hold, matching the registered digit.
   lz_blank_mask #(
      .NUM_DIGITS(NUM_DIGITS)
   ) u_lz_blank_mask (
      .value(active_val_n),
      .mask (blank_mask)
   );

   always_comb begin
      digit_n      = DIGIT_BLANK;
      dp_n         = 1'b0;
      onehot       = '0;
      onehot_full  = '0;
      frame_done_n = (state_n == SHOW) && (cnt_n == SLOT_LAST) && (idx_n == IDX_LAST);
      if (state_n != IDLE) begin
         digit_n = (lz_blank && blank_mask[idx_n]) ? DIGIT_BLANK : active_val_n[4*idx_n +: 4];
         dp_n    = active_dp_n[idx_n];
         if (state_n == SHOW) onehot[idx_n] = 1'b1;
      end
      onehot_full[NUM_DIGITS-1:0] = onehot;
      anode_full = anode_drive(onehot_full, ANODE_ACTIVE_LOW);
      anode_n    = anode_full[NUM_DIGITS-1:0];
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a 4-digit, 8-cycle-slot configuration.
module tb_display_scan_controller;
   import display_pkg::*;

   localparam int ND = 4;
   localparam int SD = 8;
   localparam int BC = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic          load;
   logic [15:0]   value;
   logic [3:0]    dp_mask;
   logic          lz_blank;
   logic [3:0]    digit;
   logic          dp;
   logic [3:0]    anode;
   logic          frame_done;
   scan_state_t   dbg_state;
   logic          dbg_pending;

   int checks   = 0;
   int failures = 0;

   display_scan_controller #(
      .NUM_DIGITS      (ND),
      .SCAN_DIV        (SD),
      .BLANK_CYCLES    (BC),
      .ANODE_ACTIVE_LOW(1'b1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .dp_mask    (dp_mask),
      .lz_blank   (lz_blank),
      .digit      (digit),
      .dp         (dp),
      .anode      (anode),
      .frame_done (frame_done),
      .dbg_state  (dbg_state),
      .dbg_pending(dbg_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks one full frame starting at the sample point of digit 0's first blank cycle,
   // optionally strobing up to two loads at given frame cycles.
   task automatic check_frame(input string name, input logic [15:0] exp_dig,
                              input logic [3:0] exp_dp,
                              input int ld_a, input logic [15:0] va, input logic [3:0] da,
                              input int ld_b, input logic [15:0] vb, input logic [3:0] db);
      logic [3:0] ea;
      for (int s = 0; s < ND; s++) begin
         for (int c = 0; c < SD; c++) begin
            ea = (c < BC) ? 4'b1111 : ~(4'b0001 << s);
            check($sformatf("%s anode s%0d c%0d", name, s, c), 32'(anode), 32'(ea));
            check($sformatf("%s digit s%0d c%0d", name, s, c), 32'(digit), 32'(exp_dig[4*s +: 4]));
            check($sformatf("%s dp s%0d c%0d", name, s, c), 32'(dp), 32'(exp_dp[s]));
            check($sformatf("%s frame_done s%0d c%0d", name, s, c), 32'(frame_done),
                  32'((s == ND - 1) && (c == SD - 1)));
            if (s * SD + c == ld_a) begin
               load = 1'b1; value = va; dp_mask = da;
            end else if (s * SD + c == ld_b) begin
               load = 1'b1; value = vb; dp_mask = db;
            end else begin
               load = 1'b0;
            end
            step();
         end
      end
      load = 1'b0;
   endtask

   initial begin
      reset_n  = 1'b1;
      enable   = 1'b0;
      load     = 1'b0;
      value    = 16'h0000;
      dp_mask  = 4'b0000;
      lz_blank = 1'b0;
      #2;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst anode", 32'(anode), 32'h0000000f);
      check("rst digit", 32'(digit), 32'h0000000f);
      check("rst dp", 32'(dp), 32'h0);
      check("rst frame_done", 32'(frame_done), 32'h0);
      check("rst state", 32'(dbg_state), 32'(IDLE));
      check("rst pending", 32'(dbg_pending), 32'h0);
      reset_n = 1'b1;
      step();
      check("idle hold state", 32'(dbg_state), 32'(IDLE));
      check("idle hold anode", 32'(anode), 32'h0000000f);

      // Load while idle goes straight to active.
      enable = 1'b1; load = 1'b1; value = 16'h1234;
      step();
      check_frame("f1234a", 16'h1234, 4'b0000, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      check_frame("f1234b", 16'h1234, 4'b0000, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      // Leading-zero blanking.
      lz_blank = 1'b1;
      check_frame("lz_pre", 16'h1234, 4'b0000, 5, 16'h0050, 4'h0, -1, 16'h0, 4'h0);
      check("pending after boundary", 32'(dbg_pending), 32'h0);
      check_frame("lz0050", 16'hFF50, 4'b0000, 10, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
      check_frame("lz0000", 16'hFFF0, 4'b0000, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      // Double buffering: last load in a frame wins, nothing tears.
      lz_blank = 1'b0;
      check_frame("buf_old", 16'h0000, 4'b0000, 3, 16'h1111, 4'h0, 12, 16'h2222, 4'h0);
      check_frame("buf2222", 16'h2222, 4'b0000, 4, 16'h5555, 4'h0, 31, 16'h9999, 4'h0);
      check("pending after boundary load", 32'(dbg_pending), 32'h0);
      check_frame("bnd9999", 16'h9999, 4'b0000, 0, 16'h9999, 4'b0100, -1, 16'h0, 4'h0);
      check_frame("dp0100", 16'h9999, 4'b0100, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      // Reset mid-SHOW of digit 1.
      repeat (12) step();
      check("pre-reset state", 32'(dbg_state), 32'(SHOW));
      reset_n = 1'b0;
      #1;
      check("midrst anode", 32'(anode), 32'h0000000f);
      check("midrst digit", 32'(digit), 32'h0000000f);
      check("midrst state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();
      check_frame("post_rst", 16'h0000, 4'b0000, 0, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
      check("pending cleared by frame", 32'(dbg_pending), 32'h0);

      // Enable drop mid-slot.
      repeat (13) step();
      enable = 1'b0;
      step();
      check("en_off anode", 32'(anode), 32'h0000000f);
      check("en_off digit", 32'(digit), 32'h0000000f);
      check("en_off frame_done", 32'(frame_done), 32'h0);
      check("en_off state", 32'(dbg_state), 32'(IDLE));
      enable = 1'b1;
      step();
      check("restart state", 32'(dbg_state), 32'(BLANK));
      check_frame("restart", 16'h1234, 4'b0000, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes one shared seven_segment_decoder across NUM_DIGITS common-anode/cathode digits.
- Drives the decoder's 4-bit DIGIT input, one-hot digit enables and the decimal point.
- Inserts a blanking interval between digits to suppress ghosting.
- Double-buffers the displayed value so a new value never tears mid-frame. Sits between the timer counter logic and the display pins.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (legal 1..8).
- SCAN_DIV, 100000, clock cycles per digit slot, blank time included.
- BLANK_CYCLES, 1000, cycles at slot start with all anodes off. Must satisfy 1 <= BLANK_CYCLES < SCAN_DIV.
- ANODE_ACTIVE_LOW, 1, 1 = ANODE bits are active-low, 0 = active-high.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  1 = scanning, 0 = display dark.
- LOAD  in  1  single-cycle strobe; capture VALUE/DP_MASK into shadow.
- VALUE  in  4*NUM_DIGITS  BCD nibbles; nibble i is digit i, digit 0 = LSD.
- DP_MASK  in  NUM_DIGITS  bit i lights the DP of digit i.
- LZ_BLANK  in  1  1 = leading-zero blanking on.
- DIGIT  out  4  nibble to the decoder; 4'hF = blank (decoder default).
- DP  out  1  decimal point for the current digit, active-high.
- ANODE  out  NUM_DIGITS  digit enables, one-hot or all-off, polarity per ANODE_ACTIVE_LOW.
- FRAME_DONE  out  1  one-cycle pulse on the last cycle of a frame.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RESET_N. All state is reset asynchronously.
- Reset values:
  - ANODE all inactive, DIGIT=4'hF, DP=0, FRAME_DONE=0.
  - Active and shadow registers 0, pending=0, idx=0, slot counter 0, state IDLE.
- All outputs are registered.
- States:
  - IDLE: anodes off, DIGIT=4'hF, idx=0, counter=0. ENABLE=1 -> BLANK on the next edge.
  - BLANK: counter runs 0..BLANK_CYCLES-1 with anodes off. DIGIT/DP already show digit idx. At the last count -> SHOW.
  - SHOW: anode idx is active. Counter continues to SCAN_DIV-1, then -> BLANK with counter=0 and idx=(idx+1) mod NUM_DIGITS.
- Frame boundary: last SHOW cycle with idx=NUM_DIGITS-1.
  - FRAME_DONE=1 for exactly that cycle.
  - If pending=1, shadow -> active on that edge and pending is cleared. Digit 0 of the next frame shows the new value.
- LOAD handling:
  - LOAD=1 captures VALUE and DP_MASK into shadow and sets pending.
  - Repeated LOADs within a frame: the last one wins.
  - LOAD on the boundary cycle: the VALUE/DP_MASK present that cycle go straight to active; pending ends 0.
  - LOAD or pending while in IDLE: transfer to active on the next edge.
- ENABLE deasserted in any state: next edge -> IDLE, anodes off, idx and counter cleared. No FRAME_DONE.
- Leading-zero blanking, LZ_BLANK=1:
  - Digit i (i>0) is blanked when nibbles NUM_DIGITS-1..i of active are all 0. Digit 0 is never blanked.
  - A blanked digit outputs DIGIT=4'hF. DP still follows DP_MASK.
  - The mask is computed from the active register only.
- Nibbles 10..15 in VALUE pass through unchanged; the decoder blanks them.
- Counter width is $clog2(SCAN_DIV). No wrap except the defined slot rollover.
- Reset mid-frame: immediate dark outputs. Shadow and pending are lost.

Decomposition:
- Package display_pkg:
  - Constant DIGIT_BLANK=4'hF.
  - Enum scan_state_t {IDLE, BLANK, SHOW}.
  - Function to apply ANODE polarity.
- Sub-module lz_blank_mask: combinational, active value -> NUM_DIGITS blank mask.
- Prescaler and FSM stay in the top.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=1):
- Reset then ENABLE=1, LOAD VALUE=16'h1234 -> per slot: 2 cycles ANODE=4'b1111, then 6 cycles one-hot low at 1110, 1101, 1011, 0111. DIGIT is 4,3,2,1. FRAME_DONE pulses every 32 cycles.
- LZ_BLANK=1, VALUE=16'h0050 -> DIGIT sequence 0,5,F,F. VALUE=16'h0000 -> 0,F,F,F.
- LOAD 16'h1111 mid-frame, then LOAD 16'h2222 in the next slot -> the current frame keeps the old value; the next frame shows all 2s. 1111 is never displayed.
- LOAD 16'h9999 exactly on the FRAME_DONE cycle -> the following digit 0 slot shows 9. pending=0 afterwards.
- DP_MASK=4'b0100 -> DP=1 only during the digit-2 slot (BLANK and SHOW).
- RESET_N low mid-SHOW for 1 cycle, and ENABLE low mid-slot -> ANODE=4'b1111 immediately / next edge. The restart begins at digit 0 with a full BLANK.
